// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared state/winner encodings, widths and hand arithmetic helpers (soft_total only with SOFT_ACE_EN)
package blackjack_pkg;

    localparam int CARD_W  = 4;
    localparam int TOTAL_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        P1_TURN,
        P1_WAIT,
        P2_TURN,
        P2_WAIT,
        SETTLE
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    function automatic logic [TOTAL_W-1:0] add_card(input logic [TOTAL_W-1:0] hard,
                                                     input logic [CARD_W-1:0]  card);
        logic [TOTAL_W:0] s;
        s = {1'b0, hard} + {2'b00, card};
        return s[TOTAL_W] ? '1 : s[TOTAL_W-1:0];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

`ifdef SOFT_ACE_EN
    function automatic logic [TOTAL_W-1:0] soft_total(input logic [TOTAL_W-1:0] hard,
                                                       input logic               ace,
                                                       input int                 limit);
        logic [TOTAL_W:0] s;
        s = {1'b0, hard} + 6'd10;
        return (ace && s <= 6'(limit)) ? s[TOTAL_W-1:0] : hard;
    endfunction
`endif

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle strobe on a rising edge of a level input synchronous to clk
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // remember the previously sampled level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prev_q <= 1'b0;
        else         prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: two-player blackjack round sequencer with a shared dealer handshake; SOFT_ACE_EN enables soft-ace totals
module turn_scheduler
    import blackjack_pkg::*;
#(
    parameter int BANK_INIT  = 100,
    parameter int BUST_LIMIT = 21
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               p1_hit,
    input  logic               p1_stand,
    input  logic               p2_hit,
    input  logic               p2_stand,
    input  logic               start,
    input  logic [7:0]         p1_bet,
    input  logic [7:0]         p2_bet,
    output logic               deal_req,
    input  logic               card_valid,
    input  logic [CARD_W-1:0]  card_value,
    output logic [TOTAL_W-1:0] p1_total,
    output logic [TOTAL_W-1:0] p2_total,
    output logic [7:0]         p1_bank,
    output logic [7:0]         p2_bank,
    output logic [1:0]         winner,
    output logic               round_done
);

    localparam logic [TOTAL_W-1:0] LIM      = TOTAL_W'(BUST_LIMIT);
    localparam logic [7:0]         BANK_RST = 8'(BANK_INIT);

    logic [4:0] btn, rise;
    logic       p1_hit_rise, p1_stand_rise, p2_hit_rise, p2_stand_rise, start_rise;

    assign btn = {start, p2_stand, p2_hit, p1_stand, p1_hit};
    assign {start_rise, p2_stand_rise, p2_hit_rise, p1_stand_rise, p1_hit_rise} = rise;

    genvar g;
    for (g = 0; g < 5; g++) begin : g_edge
        rise_detect u_rise (
            .clk    (clk),
            .resetn (resetn),
            .d_i    (btn[g]),
            .rise_o (rise[g])
        );
    end

    state_t               state_q, state_d;
    winner_t              winner_q, winner_d, settle_w;
    logic                 deal_q, deal_d, done_q, done_d;
    logic [TOTAL_W-1:0]   p1_hard_q, p1_hard_d, p2_hard_q, p2_hard_d;
    logic [7:0]           bet1_q, bet1_d, bet2_q, bet2_d;
    logic [7:0]           bank1_q, bank1_d, bank2_q, bank2_d;
    logic [TOTAL_W-1:0]   p1_new_hard, p2_new_hard;
    logic [TOTAL_W-1:0]   p1_tot, p2_tot, p1_new_tot, p2_new_tot;
    logic                 p1_bust, p2_bust;

    assign p1_new_hard = add_card(p1_hard_q, card_value);
    assign p2_new_hard = add_card(p2_hard_q, card_value);

`ifdef SOFT_ACE_EN
    logic p1_ace_q, p1_ace_d, p2_ace_q, p2_ace_d, p1_new_ace, p2_new_ace;

    assign p1_new_ace = p1_ace_q | (card_value == CARD_W'(1));
    assign p2_new_ace = p2_ace_q | (card_value == CARD_W'(1));
    assign p1_tot     = soft_total(p1_hard_q, p1_ace_q, BUST_LIMIT);
    assign p2_tot     = soft_total(p2_hard_q, p2_ace_q, BUST_LIMIT);
    assign p1_new_tot = soft_total(p1_new_hard, p1_new_ace, BUST_LIMIT);
    assign p2_new_tot = soft_total(p2_new_hard, p2_new_ace, BUST_LIMIT);

    // ace flags: cleared on round start, set by any accepted ace for the player on turn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p1_ace_q <= 1'b0;
            p2_ace_q <= 1'b0;
        end else begin
            p1_ace_q <= p1_ace_d;
            p2_ace_q <= p2_ace_d;
        end
    end

    // ace next-state follows the same round-start and card-accept events as the hard totals
    always_comb begin
        p1_ace_d = p1_ace_q;
        p2_ace_d = p2_ace_q;
        if (state_q == IDLE && start_rise) begin
            p1_ace_d = 1'b0;
            p2_ace_d = 1'b0;
        end
        if (state_q == P1_WAIT && card_valid && deal_q) p1_ace_d = p1_new_ace;
        if (state_q == P2_WAIT && card_valid && deal_q) p2_ace_d = p2_new_ace;
    end
`else
    assign p1_tot     = p1_hard_q;
    assign p2_tot     = p2_hard_q;
    assign p1_new_tot = p1_new_hard;
    assign p2_new_tot = p2_new_hard;
`endif

    assign p1_bust  = p1_tot > LIM;
    assign p2_bust  = p2_tot > LIM;
    assign settle_w = ((p1_bust && p2_bust) || p1_tot == p2_tot) ? WIN_NONE :
                      (p2_bust || (!p1_bust && p1_tot > p2_tot)) ? WIN_P1 : WIN_P2;

    // round state, hands, wagers and balances
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            winner_q  <= WIN_NONE;
            deal_q    <= 1'b0;
            done_q    <= 1'b0;
            p1_hard_q <= '0;
            p2_hard_q <= '0;
            bet1_q    <= '0;
            bet2_q    <= '0;
            bank1_q   <= BANK_RST;
            bank2_q   <= BANK_RST;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            deal_q    <= deal_d;
            done_q    <= done_d;
            p1_hard_q <= p1_hard_d;
            p2_hard_q <= p2_hard_d;
            bet1_q    <= bet1_d;
            bet2_q    <= bet2_d;
            bank1_q   <= bank1_d;
            bank2_q   <= bank2_d;
        end
    end

    // turn sequencing: stand beats a simultaneous hit, one card per request, settlement moves the loser's bet
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        deal_d    = deal_q;
        done_d    = 1'b0;
        p1_hard_d = p1_hard_q;
        p2_hard_d = p2_hard_q;
        bet1_d    = bet1_q;
        bet2_d    = bet2_q;
        bank1_d   = bank1_q;
        bank2_d   = bank2_q;
        case (state_q)
            IDLE: if (start_rise) begin
                bet1_d    = (p1_bet > bank1_q) ? bank1_q : p1_bet;
                bet2_d    = (p2_bet > bank2_q) ? bank2_q : p2_bet;
                p1_hard_d = '0;
                p2_hard_d = '0;
                winner_d  = WIN_NONE;
                state_d   = P1_TURN;
            end
            P1_TURN: if (p1_stand_rise) begin
                state_d = P2_TURN;
            end else if (p1_hit_rise) begin
                deal_d  = 1'b1;
                state_d = P1_WAIT;
            end
            P1_WAIT: if (card_valid && deal_q) begin
                p1_hard_d = p1_new_hard;
                deal_d    = 1'b0;
                state_d   = (p1_new_tot > LIM) ? P2_TURN : P1_TURN;
            end
            P2_TURN: if (p2_stand_rise) begin
                state_d = SETTLE;
            end else if (p2_hit_rise) begin
                deal_d  = 1'b1;
                state_d = P2_WAIT;
            end
            P2_WAIT: if (card_valid && deal_q) begin
                p2_hard_d = p2_new_hard;
                deal_d    = 1'b0;
                state_d   = (p2_new_tot > LIM) ? SETTLE : P2_TURN;
            end
            SETTLE: begin
                winner_d = settle_w;
                bank1_d  = (settle_w == WIN_P1) ? sat_add8(bank1_q, bet2_q) :
                           (settle_w == WIN_P2) ? bank1_q - bet1_q : bank1_q;
                bank2_d  = (settle_w == WIN_P2) ? sat_add8(bank2_q, bet1_q) :
                           (settle_w == WIN_P1) ? bank2_q - bet2_q : bank2_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign deal_req   = deal_q;
    assign p1_total   = p1_tot;
    assign p2_total   = p2_tot;
    assign p1_bank    = bank1_q;
    assign p2_bank    = bank2_q;
    assign winner     = winner_q;
    assign round_done = done_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed and random rounds against a card-list reference model, scoreboard checked on round_done
module tb_turn_scheduler;

    localparam int LIMIT = 21;

    logic       clk, resetn;
    logic       p1_hit, p1_stand, p2_hit, p2_stand, start;
    logic [7:0] p1_bet, p2_bet;
    logic       deal_req, card_valid;
    logic [3:0] card_value;
    logic [4:0] p1_total, p2_total;
    logic [7:0] p1_bank, p2_bank;
    logic [1:0] winner;
    logic       round_done;

    turn_scheduler #(.BANK_INIT(100), .BUST_LIMIT(21)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .p1_hit     (p1_hit),
        .p1_stand   (p1_stand),
        .p2_hit     (p2_hit),
        .p2_stand   (p2_stand),
        .start      (start),
        .p1_bet     (p1_bet),
        .p2_bet     (p2_bet),
        .deal_req   (deal_req),
        .card_valid (card_valid),
        .card_value (card_value),
        .p1_total   (p1_total),
        .p2_total   (p2_total),
        .p1_bank    (p1_bank),
        .p2_bank    (p2_bank),
        .winner     (winner),
        .round_done (round_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int w;
        int t1;
        int t2;
        int k1;
        int k2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   k1, k2;
    bit   prev_done = 1'b0;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
        end
    endtask

    // hand value straight from the card list: aces may count 11 when that does not bust
    function automatic int tot(input int c[$]);
        int h = 0;
        bit ace = 1'b0;
        foreach (c[i]) begin
            h += c[i];
            if (c[i] == 1) ace = 1'b1;
        end
`ifdef SOFT_ACE_EN
        if (ace && h + 10 <= LIMIT) return h + 10;
`endif
        return (h > 31) ? 31 : h;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (resetn) begin
            if (round_done) begin
                if (prev_done) chk("round_done_single_pulse", 1, 0);
                if (q.size() == 0) begin
                    chk("round_done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("winner", int'(winner), e.w);
                    chk("p1_total", int'(p1_total), e.t1);
                    chk("p2_total", int'(p2_total), e.t2);
                    chk("p1_bank", int'(p1_bank), e.k1);
                    chk("p2_bank", int'(p2_bank), e.k2);
                end
            end
            prev_done = round_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic pulse_start(input int b1, input int b2);
        @(negedge clk);
        p1_bet = 8'(b1);
        p2_bet = 8'(b2);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic set_hit(input int p, input logic v);
        if (p == 1) p1_hit = v;
        else        p2_hit = v;
    endtask

    task automatic hit(input int p, input int c, input int dly, input bit noise);
        @(negedge clk);
        set_hit(p, 1'b1);
        @(negedge clk);
        set_hit(p, 1'b0);
        chk("deal_req_raised", int'(deal_req), 1);
        for (int i = 0; i < dly; i++) begin
            if (noise) set_hit(p, (i == 0));
            @(negedge clk);
            chk("deal_req_held", int'(deal_req), 1);
        end
        set_hit(p, 1'b0);
        card_valid = 1'b1;
        card_value = 4'(c);
        @(negedge clk);
        card_valid = 1'b0;
        chk("deal_req_dropped", int'(deal_req), 0);
    endtask

    task automatic stand(input int p, input bit both);
        @(negedge clk);
        if (p == 1) begin
            p1_stand = 1'b1;
            p1_hit   = both;
        end else begin
            p2_stand = 1'b1;
            p2_hit   = both;
        end
        @(negedge clk);
        p1_stand = 1'b0;
        p2_stand = 1'b0;
        p1_hit   = 1'b0;
        p2_hit   = 1'b0;
    endtask

    task automatic play(input int b1, input int b2, input int c1[$], input int c2[$],
                        input int dly, input bit noise, input bit both);
        exp_t e;
        int   bt1, bt2, t1, t2, w;
        int   pre[$];
        bit   seen;
        bt1 = (b1 > k1) ? k1 : b1;
        bt2 = (b2 > k2) ? k2 : b2;
        t1  = tot(c1);
        t2  = tot(c2);
        if ((t1 > LIMIT && t2 > LIMIT) || t1 == t2) w = 0;
        else if (t2 > LIMIT || (t1 <= LIMIT && t1 > t2)) w = 1;
        else w = 2;
        if (w == 1) begin
            k1 = (k1 + bt2 > 255) ? 255 : k1 + bt2;
            k2 = k2 - bt2;
        end else if (w == 2) begin
            k2 = (k2 + bt1 > 255) ? 255 : k2 + bt1;
            k1 = k1 - bt1;
        end
        e.w = w; e.t1 = t1; e.t2 = t2; e.k1 = k1; e.k2 = k2;
        q.push_back(e);
        pulse_start(b1, b2);
        if (noise) begin
            @(negedge clk);
            p2_hit     = 1'b1;
            p2_stand   = 1'b1;
            card_valid = 1'b1;
            card_value = 4'd9;
            @(negedge clk);
            p2_hit     = 1'b0;
            p2_stand   = 1'b0;
            card_valid = 1'b0;
            chk("deal_req_idle_in_turn", int'(deal_req), 0);
        end
        pre.delete();
        foreach (c1[i]) begin
            hit(1, c1[i], dly, noise);
            pre.push_back(c1[i]);
            chk("p1_running_total", int'(p1_total), tot(pre));
        end
        if (t1 <= LIMIT) stand(1, both);
        pre.delete();
        foreach (c2[i]) begin
            hit(2, c2[i], dly, 1'b0);
            pre.push_back(c2[i]);
            chk("p2_running_total", int'(p2_total), tot(pre));
        end
        if (t2 <= LIMIT) stand(2, both);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = round_done;
        end
        chk("round_done_seen", int'(seen), 1);
        repeat (2) @(negedge clk);
        chk("p1_total_hold", int'(p1_total), t1);
        chk("winner_hold", int'(winner), w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        k1 = 100;
        k2 = 100;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a[$], b[$];
        resetn = 1'b0;
        {p1_hit, p1_stand, p2_hit, p2_stand, start, card_valid} = '0;
        p1_bet = '0; p2_bet = '0; card_value = '0;
        k1 = 100; k2 = 100;
        repeat (3) @(negedge clk);
        chk("rst_deal_req", int'(deal_req), 0);
        chk("rst_p1_bank", int'(p1_bank), 100);
        chk("rst_p2_bank", int'(p2_bank), 100);
        chk("rst_p1_total", int'(p1_total), 0);
        chk("rst_p2_total", int'(p2_total), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_round_done", int'(round_done), 0);
        resetn = 1'b1;

        a = '{10, 9}; b = '{10, 7};
        play(20, 10, a, b, 1, 1'b0, 1'b0);
        chk("basic_bank1", int'(p1_bank), 110);
        chk("basic_bank2", int'(p2_bank), 90);

        pulse_start(10, 10);
        hit(1, 5, 0, 1'b0);
        stand(1, 1'b0);
        @(negedge clk);
        p2_hit = 1'b1;
        @(negedge clk);
        p2_hit = 1'b0;
        chk("p2_wait_deal_req", int'(deal_req), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_deal_req", int'(deal_req), 0);
        chk("async_rst_bank1", int'(p1_bank), 100);
        chk("async_rst_bank2", int'(p2_bank), 100);
        chk("async_rst_p1_total", int'(p1_total), 0);
        chk("async_rst_winner", int'(winner), 0);
        @(negedge clk);
        resetn = 1'b1;
        k1 = 100; k2 = 100;

        a = '{10, 10, 5}; b.delete();
        play(20, 20, a, b, 0, 1'b0, 1'b0);
        chk("bust_bank1", int'(p1_bank), 80);
        chk("bust_bank2", int'(p2_bank), 120);

        do_reset();
        a.delete(); b = '{5};
        play(150, 10, a, b, 2, 1'b0, 1'b1);
        chk("clamp_bank1", int'(p1_bank), 0);
        chk("clamp_bank2", int'(p2_bank), 200);

        do_reset();
        a = '{4, 6}; b = '{9};
        play(30, 30, a, b, 7, 1'b1, 1'b0);

        a = '{1, 10}; b.delete();
        play(5, 5, a, b, 0, 1'b0, 1'b0);
`ifdef SOFT_ACE_EN
        chk("ace_total", int'(p1_total), 21);
`else
        chk("ace_total", int'(p1_total), 11);
`endif

        do_reset();
        for (int r = 0; r < 40; r++) begin
            a.delete();
            b.delete();
            while (tot(a) <= LIMIT && $urandom_range(0, 3) != 0) a.push_back(int'($urandom_range(1, 10)));
            while (tot(b) <= LIMIT && $urandom_range(0, 3) != 0) b.push_back(int'($urandom_range(1, 10)));
            play(int'($urandom_range(0, 150)), int'($urandom_range(0, 150)), a, b,
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 SHALL have parameter BANK_INIT, default 100: reset value of both player banks.
REQ-002 SHALL have parameter BUST_LIMIT, default 21: highest non-bust hand total.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports p1_hit, p1_stand, p2_hit, p2_stand, input, 1 bit each: level, synchronous to clk, active-high; rising edges detected internally.
REQ-006 SHALL have port start, input, 1 bit: rising edge begins a round.
REQ-007 SHALL have ports p1_bet, p2_bet, input, 8 bits each: requested wagers.
REQ-008 SHALL have port deal_req, output, 1 bit: card request to the shared dealer.
REQ-009 SHALL have port card_valid, input, 1 bit, and port card_value, input, 4 bits: dealer reply with value 1..10.
REQ-010 SHALL have ports p1_total, p2_total, output, 5 bits each: current hand totals.
REQ-011 SHALL have ports p1_bank, p2_bank, output, 8 bits each: player balances.
REQ-012 SHALL have port winner, output, 2 bits: 0 none/push, 1 player 1, 2 player 2.
REQ-013 SHALL have port round_done, output, 1 bit: one-cycle pulse after settlement.

Function
REQ-014 SHALL implement states IDLE, P1_TURN, P1_WAIT, P2_TURN, P2_WAIT, SETTLE.
REQ-015 IDLE + start edge: latch each bet clamped to that player's bank, clear totals and winner, go to P1_TURN.
REQ-016 P1_TURN: p1_hit edge -> assert deal_req, go P1_WAIT; p1_stand edge -> P2_TURN; same-cycle hit and stand edges -> stand wins.
REQ-017 P1_WAIT: deal_req held high until the cycle card_valid=1; that cycle add card_value to p1_total and drop deal_req next cycle.
REQ-018 After a card: total > BUST_LIMIT -> P2_TURN, else -> P1_TURN; no hit queuing; edges arriving in WAIT are ignored.
REQ-019 P2_TURN/P2_WAIT SHALL mirror REQ-016..018 for player 2, exiting to SETTLE.
REQ-020 Inputs of the player not on turn, and card_valid without deal_req, SHALL be ignored.
REQ-021 SETTLE, one cycle: both bust or equal totals -> winner 0, banks unchanged; one bust -> other wins; else higher total wins.
REQ-022 Winner bank += loser's latched bet, loser bank -= same amount; arithmetic 8-bit, winner bank saturates at 255, loser cannot underflow since bet clamped.
REQ-023 round_done SHALL pulse in the cycle after SETTLE, state returns to IDLE; totals and winner hold until next start.
REQ-024 Totals SHALL be 5 bits; maximum reachable value 31, no wrap.

Reset
REQ-025 resetn low SHALL immediately force IDLE, deal_req 0, totals 0, winner 0, round_done 0, latched bets 0, banks BANK_INIT, edge-detect registers 0, including mid-round.

Configuration
REQ-026 With SOFT_ACE_EN defined, a per-player ace flag SHALL be kept and reported total = hard + 10 when an ace was drawn and hard + 10 <= BUST_LIMIT; bust and settlement use reported total.
REQ-027 Without SOFT_ACE_EN, card_value 1 SHALL count as 1 and no ace logic SHALL exist.

Structure
REQ-028 State enum, winner codes and card width SHALL live in shared package blackjack_pkg.
REQ-029 One sub-module, rise_detect (per-input edge detector), SHALL be instantiated per button/start input.

Verification
REQ-030 Bets 20/10, p1 hits 10,9 stands, p2 hits 10,7 stands -> winner 1, banks 110/90, round_done one pulse.
REQ-031 p1 draws 10,10,5 -> auto pass to P2 at 25; p2 stands at 0 -> winner 2, banks 80/120.
REQ-032 Bet 150 with bank 100 -> latched bet 100; loss -> bank 0, no underflow.
REQ-033 card_valid delayed 7 cycles -> deal_req high exactly until acceptance; p2_hit during P1 turn and p1_hit during P1_WAIT -> no effect.
REQ-034 resetn low during P2_WAIT -> deal_req 0, banks 100/100, IDLE asynchronously.
REQ-035 SOFT_ACE_EN: p1 draws 1,10 -> p1_total 21; without it -> 11.
